// File: rtl/lin_recur_gen.sv
// lin_recur_gen: sum of a tap-selected subset of the last ORDER terms,
// streamed over valid/ready, with term limit and wrap/saturate overflow.
module lin_recur_gen #(
  parameter int WIDTH = 32,
  parameter int ORDER = 3,
  parameter int CNT_W = 16,
  parameter bit SAT = 1'b0,
  parameter logic [ORDER-1:0] DEF_TAPS = 3'b011,
  parameter logic [ORDER*WIDTH-1:0] DEF_SEED = {32'd1, 64'd0},
  parameter bit AUTO_START = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [ORDER-1:0]       cfg_taps,
  input  logic [ORDER*WIDTH-1:0] cfg_seed,
  input  logic [CNT_W-1:0]       cfg_limit,
  input  logic                   start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       seq_o,
  output logic [CNT_W-1:0]       term_idx,
  output logic                   ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int SW = WIDTH + $clog2(ORDER) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ORDER*WIDTH-1:0] r_hist;
  logic [ORDER*WIDTH-1:0] r_shadow;
  logic [ORDER-1:0]       r_taps;
  logic [CNT_W-1:0]       r_limit;
  logic [CNT_W-1:0]       r_idx;
  logic                   r_ovf;

  logic [SW-1:0]          w_sum;
  logic                   w_of;
  logic [CNT_W-1:0]       w_idx_nx;
  logic                   w_last;
  logic                   w_xfer;
  logic                   w_start;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < ORDER; k++) begin
      if (r_taps[k]) begin
        w_sum = w_sum + {{(SW-WIDTH){1'b0}}, r_hist[k*WIDTH +: WIDTH]};
      end
    end
  end

  assign w_of     = |w_sum[SW-1:WIDTH];
  assign seq_o    = (SAT && w_of) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
  assign w_idx_nx = r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last   = (r_limit != '0) && (w_idx_nx == r_limit);
  assign w_xfer   = (r_state == S_RUN) && out_ready;
  assign w_start  = start && (r_state != S_RUN);

  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign term_idx  = r_idx;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= AUTO_START ? S_RUN : S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (cfg_load) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_next = S_RUN;
        S_RUN:          if (out_ready && w_last) w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // cfg_load outranks start, which outranks a transfer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist   <= DEF_SEED;
      r_shadow <= DEF_SEED;
      r_taps   <= DEF_TAPS;
      r_limit  <= '0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
    end else if (cfg_load) begin
      r_hist   <= cfg_seed;
      r_shadow <= cfg_seed;
      r_taps   <= cfg_taps;
      r_limit  <= cfg_limit;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_start) begin
      r_hist <= r_shadow;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_xfer) begin
      r_hist <= {seq_o, r_hist[ORDER*WIDTH-1:WIDTH]};
      r_idx  <= w_idx_nx;
      r_ovf  <= r_ovf | w_of;
    end
  end

endmodule

// File: tb/tb_lin_recur_gen.sv
// Bench for lin_recur_gen: Padovan defaults, plus 8-bit Fibonacci
// instances in wrap and saturate modes sharing one stimulus.
module tb_lin_recur_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        p_rst, p_load, p_start, p_ready;
  logic [2:0]  p_taps;
  logic [95:0] p_seed;
  logic [15:0] p_limit;
  logic        p_valid, p_ovf, p_busy, p_done;
  logic [31:0] p_seq;
  logic [15:0] p_idx;

  logic        b_rst, b_load, b_start, b_ready;
  logic [1:0]  b_taps;
  logic [15:0] b_seed;
  logic [15:0] b_limit;
  logic        w_valid, w_ovf, w_busy, w_done;
  logic [7:0]  w_seq;
  logic [15:0] w_idx;
  logic        s_valid, s_ovf, s_busy, s_done;
  logic [7:0]  s_seq;
  logic [15:0] s_idx;

  lin_recur_gen u_pad (
    .clk(clk), .reset(p_rst), .cfg_load(p_load), .cfg_taps(p_taps),
    .cfg_seed(p_seed), .cfg_limit(p_limit), .start(p_start),
    .out_valid(p_valid), .out_ready(p_ready), .seq_o(p_seq),
    .term_idx(p_idx), .ovf(p_ovf), .busy(p_busy), .done(p_done)
  );

  lin_recur_gen #(
    .WIDTH(8), .ORDER(2), .SAT(1'b0),
    .DEF_TAPS(2'b11), .DEF_SEED({8'd1, 8'd0})
  ) u_wrap (
    .clk(clk), .reset(b_rst), .cfg_load(b_load), .cfg_taps(b_taps),
    .cfg_seed(b_seed), .cfg_limit(b_limit), .start(b_start),
    .out_valid(w_valid), .out_ready(b_ready), .seq_o(w_seq),
    .term_idx(w_idx), .ovf(w_ovf), .busy(w_busy), .done(w_done)
  );

  lin_recur_gen #(
    .WIDTH(8), .ORDER(2), .SAT(1'b1),
    .DEF_TAPS(2'b11), .DEF_SEED({8'd1, 8'd0})
  ) u_sat (
    .clk(clk), .reset(b_rst), .cfg_load(b_load), .cfg_taps(b_taps),
    .cfg_seed(b_seed), .cfg_limit(b_limit), .start(b_start),
    .out_valid(s_valid), .out_ready(b_ready), .seq_o(s_seq),
    .term_idx(s_idx), .ovf(s_ovf), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic [7:0] w;
    logic [7:0] s;
    logic       ovf;
  } vec_t;

  vec_t        tbl [14];
  logic [63:0] q [$];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Padovan a(n) = a(n-2) + a(n-3), a0=0, a1=1, a2=1
  function automatic logic [63:0] pad(input int n);
    logic [63:0] a [$];
    a = '{64'd0, 64'd1, 64'd1};
    for (int i = 3; i <= n; i++) a.push_back(a[i-2] + a[i-3]);
    return a[n];
  endfunction

  task automatic pad_fill(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(pad(i));
  endtask

  task automatic pad_run(input int n);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      chk("pad_valid", p_valid, 1);
      if (q.size() == 0) begin
        chk("pad_queue_empty", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pad_seq", p_seq, e);
      end
      chk("pad_idx", p_idx, i);
      @(negedge clk);
    end
  endtask

  task automatic pad_reset();
    p_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", p_valid, 1);
    chk("rst_busy", p_busy, 1);
    chk("rst_done", p_done, 0);
    chk("rst_idx", p_idx, 0);
    chk("rst_ovf", p_ovf, 0);
    p_rst = 1'b1;
    pad_fill(50);
  endtask

  task automatic lim_run();
    logic [63:0] e;
    int cnt;
    cnt = 0;
    q = '{64'd1, 64'd2, 64'd3, 64'd5, 64'd8};
    for (int c = 0; c < 20 && !w_done; c++) begin
      if (w_valid) begin
        cnt++;
        if (q.size() == 0) begin
          chk("lim_extra_term", 1, 0);
        end else begin
          e = q.pop_front();
          chk("lim_seq", w_seq, e);
        end
      end
      @(negedge clk);
    end
    chk("lim_count", cnt, 5);
    chk("lim_done", w_done, 1);
    chk("lim_valid", w_valid, 0);
    chk("lim_idx", w_idx, 5);
    chk("lim_sat_done", s_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{8'd1,   8'd1,   1'b0}, '{8'd2,   8'd2,   1'b0},
      '{8'd3,   8'd3,   1'b0}, '{8'd5,   8'd5,   1'b0},
      '{8'd8,   8'd8,   1'b0}, '{8'd13,  8'd13,  1'b0},
      '{8'd21,  8'd21,  1'b0}, '{8'd34,  8'd34,  1'b0},
      '{8'd55,  8'd55,  1'b0}, '{8'd89,  8'd89,  1'b0},
      '{8'd144, 8'd144, 1'b0}, '{8'd233, 8'd233, 1'b0},
      '{8'd121, 8'd255, 1'b1}, '{8'd98,  8'd255, 1'b1}
    };
    p_rst = 1'b0; p_load = 1'b0; p_start = 1'b0; p_ready = 1'b1;
    p_taps = 3'b011; p_seed = {32'd1, 64'd0}; p_limit = '0;
    b_rst = 1'b0; b_load = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    b_taps = 2'b11; b_seed = {8'd1, 8'd0}; b_limit = '0;

    repeat (3) begin
      pad_reset();
      pad_run(50);
      chk("pad_ovf", p_ovf, 0);
    end

    pad_reset();
    pad_run(20);
    p_rst = 1'b0;
    @(negedge clk);
    chk("midrst_idx", p_idx, 0);
    chk("midrst_seq", p_seq, 0);
    p_rst = 1'b1;
    pad_fill(12);
    pad_run(12);

    pad_reset();
    pad_run(7);
    p_load = 1'b1;
    @(negedge clk);
    p_load = 1'b0;
    chk("load_valid", p_valid, 0);
    chk("load_busy", p_busy, 0);
    chk("load_idx", p_idx, 0);
    p_load = 1'b1; p_start = 1'b1;
    @(negedge clk);
    p_load = 1'b0; p_start = 1'b0;
    chk("loadstart_valid", p_valid, 0);
    @(negedge clk);
    chk("loadstart_idle", p_valid, 0);
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    pad_fill(10);
    pad_run(10);

    b_rst = 1'b0;
    repeat (2) @(negedge clk);
    b_rst = 1'b1;
    b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    chk("b_idle_w", w_valid, 0);
    chk("b_idle_s", s_valid, 0);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("tbl_wvalid", w_valid, 1);
      chk("tbl_wseq", w_seq, tbl[i].w);
      chk("tbl_sseq", s_seq, tbl[i].s);
      chk("tbl_idx", w_idx, i);
      if (i == 3) begin
        b_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_valid", w_valid, 1);
          chk("bp_seq", w_seq, 5);
          chk("bp_idx", w_idx, 3);
        end
        b_ready = 1'b1;
      end
      @(negedge clk);
      chk("tbl_wovf", w_ovf, tbl[i].ovf);
      chk("tbl_sovf", s_ovf, tbl[i].ovf);
    end

    b_limit = 16'd5;
    b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lim_run();
    repeat (3) @(negedge clk);
    chk("done_hold", w_done, 1);
    chk("done_idx_hold", w_idx, 5);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    lim_run();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
